// File: rtl/program_rom_if.sv
// Read port between the program counter (master) and the program ROM (slave).
// The master drives the enable and address; the ROM returns registered data and valid.
interface program_rom_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
);
    logic                  ce;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;

    modport master (
        output ce,
        output address,
        input  data,
        input  valid
    );

    modport slave (
        input  ce,
        input  address,
        output data,
        output valid
    );
endinterface

// File: rtl/program_rom.sv
// Fixed 16-bit instruction image with a synchronous, chip-enabled read.
// Data and valid are registered, so the read latency is exactly one clock.
module program_rom #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    program_rom_if.slave bus
);
    logic [31:0]           w_index;
    logic [15:0]           w_word16;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    assign w_index = 32'(bus.address);

    // Constant image; anything beyond index 7 reads as zero.
    always_comb begin
        w_word16 = 16'h0000;
        case (w_index)
            32'd0:   w_word16 = 16'h8001;
            32'd1:   w_word16 = 16'h4102;
            32'd2:   w_word16 = 16'h2203;
            32'd3:   w_word16 = 16'h1304;
            32'd4:   w_word16 = 16'hF405;
            32'd5:   w_word16 = 16'h0506;
            32'd6:   w_word16 = 16'hA607;
            default: w_word16 = 16'h0000;
        endcase
    end

    generate
        if (DATA_WIDTH > 16) begin : g_extend
            assign w_word = {{(DATA_WIDTH-16){1'b0}}, w_word16};
        end else if (DATA_WIDTH == 16) begin : g_exact
            assign w_word = w_word16;
        end else begin : g_truncate
            assign w_word = w_word16[DATA_WIDTH-1:0];
        end
    endgenerate

    // Data holds its last word when disabled; valid only follows an enabled read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.ce;
            if (bus.ce) begin
                r_data <= w_word;
            end
        end
    end

    assign bus.data  = r_data;
    assign bus.valid = r_valid;
endmodule

// File: tb/tb_program_rom.sv
// Self-checking bench for program_rom: directed scenarios plus randomized reads
// compared against a table-driven reference of the instruction image.
module tb_program_rom;
    localparam int AW = 3;
    localparam int DW = 16;

    logic clk;
    logic rst_n;

    program_rom_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) romBus ();

    program_rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (romBus.slave)
    );

    logic [15:0] romImage [8] = '{16'h8001, 16'h4102, 16'h2203, 16'h1304,
                                  16'hF405, 16'h0506, 16'hA607, 16'h0000};

    logic [15:0] expData;
    logic        expValid;
    int          checkCount;
    int          errorCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBoth(input string tag);
        checkOutput({tag, ".data"},  32'(romBus.data),  32'(expData));
        checkOutput({tag, ".valid"}, 32'(romBus.valid), 32'(expValid));
    endtask

    // Drive one cycle, then apply the read rules to the reference after the edge.
    task automatic applyStimulus(input logic ceIn, input logic [AW-1:0] addrIn,
                                 input string tag);
        romBus.ce      = ceIn;
        romBus.address = addrIn;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            expData  = 16'h0000;
            expValid = 1'b0;
        end else if (ceIn) begin
            expData  = romImage[addrIn];
            expValid = 1'b1;
        end else begin
            expValid = 1'b0;
        end
        checkBoth(tag);
    endtask

    initial begin
        logic [AW-1:0] order [8];
        logic [AW-1:0] tmp;
        int            j;

        checkCount = 0;
        errorCount = 0;
        expData    = 16'h0000;
        expValid   = 1'b0;

        rst_n          = 1'b0;
        romBus.ce      = 1'b1;
        romBus.address = 3'd3;
        #1;
        checkBoth("reset_immediate");
        repeat (2) begin
            @(posedge clk);
            #1;
            checkBoth("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd3, "first_read");
        checkOutput("first_read_word", 32'(romBus.data), 32'h1304);

        $display("[TB] sequential sweep");
        for (int a = 0; a < 6; a++) begin
            applyStimulus(1'b1, AW'(a), "sweep");
        end

        $display("[TB] enable gating");
        applyStimulus(1'b1, 3'd4, "gate_read");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 3'd6, "gate_hold");
        end
        checkOutput("gate_hold_word", 32'(romBus.data), 32'hF405);
        applyStimulus(1'b1, 3'd6, "gate_resume");

        $display("[TB] address wrap");
        applyStimulus(1'b1, 3'd6, "wrap6");
        applyStimulus(1'b1, 3'd7, "wrap7");
        applyStimulus(1'b1, 3'd0, "wrap0");
        checkOutput("wrap0_word", 32'(romBus.data), 32'h8001);

        $display("[TB] async reset mid-stream");
        applyStimulus(1'b1, 3'd1, "stream1");
        applyStimulus(1'b1, 3'd2, "stream2");
        #2;
        rst_n = 1'b0;
        #1;
        expData  = 16'h0000;
        expValid = 1'b0;
        checkBoth("async_reset");
        applyStimulus(1'b1, 3'd4, "reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd5, "post_reset");

        $display("[TB] randomized reads");
        for (int round = 0; round < 12; round++) begin
            for (int i = 0; i < 8; i++) order[i] = AW'(i);
            for (int i = 7; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                tmp      = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            for (int i = 0; i < 8; i++) begin
                applyStimulus(1'($urandom_range(1, 0)), order[i], "random");
            end
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, AW'(i), "exhaustive");
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/program_rom.md
Name: program_rom

Overview:
- Read-only program store holding the fixed 16-bit instruction image of the processor. Sits between the program counter (address source) and the instruction decoder.
- Read is synchronous, gated by a chip enable, with one clock cycle of latency.
- A registered valid flag marks when data holds a fresh read.

Parameters:
- ADDR_WIDTH, 3, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, word width in bits. Image words are truncated to the low DATA_WIDTH bits, or zero-extended if DATA_WIDTH > 16.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ce, input, 1, chip enable; a read is performed only when high.
- address, input, ADDR_WIDTH, word address.
- data, output, DATA_WIDTH, registered read data.
- valid, output, 1, high for the cycle(s) after an enabled read. Stays high while ce is held high.

Behaviour:
- Fixed image (hex, index:value): 0:8001, 1:4102, 2:2203, 3:1304, 4:F405, 5:0506, 6:A607, 7:0000.
- Indices >= 8 read as 0000 when ADDR_WIDTH > 3. The image is a constant case table; it is not writable.
- Reset:
  - rst_n low forces data = 0 and valid = 0 immediately, independent of clk.
  - The values are held while rst_n is low.
  - The first read can occur on the first rising clk edge after rst_n deasserts.
- Read:
  - On a rising clk edge with ce = 1: data <= image[address] and valid <= 1.
  - Latency is exactly 1 cycle, address to data.
- Hold:
  - On a rising clk edge with ce = 0: data keeps its previous value and valid <= 0.
- Address changes while ce = 0 have no effect on data.
- Back-to-back: ce held high with a new address each cycle gives one new word per cycle, no bubbles.
- Address wrap: addresses 7 -> 0 in consecutive cycles return 0000 then 8001; there is no special-case logic.
- X/Z handling: when ce = 1, the address must be known. Unknown address bits give an unknown data value in simulation only; no assertion is required.
- Reset mid-operation: asserting rst_n during streaming reads clears data and valid asynchronously. Any read in flight is discarded.
- There is no combinational path from address or ce to data or valid.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with ce = 1, address = 3 -> data = 0000, valid = 0 throughout. Release -> next edge gives data = 1304, valid = 1.
- Sequential sweep: ce = 1, address 0,1,2,3,4,5 on successive edges -> data one cycle later is 8001, 4102, 2203, 1304, F405, 0506, with valid = 1 each cycle.
- Enable gating: read address 4 (data = F405), then ce = 0 and address = 6 for 3 cycles -> data stays F405, valid = 0. Re-enable -> next edge gives A607.
- Wrap: ce = 1, address 6, 7, 0 -> data A607, 0000, 8001.
- Async reset mid-stream: during a sweep, drop rst_n between clock edges -> data = 0000 and valid = 0 before the next edge. Resume after release -> correct word at 1-cycle latency.
- Exhaustive: all 8 addresses in random order with ce randomly toggled -> compare against the image table each cycle; mismatch count = 0.
